// File: rtl/mouse_pkt_asm.sv
// Assembles PS/2 mouse bytes into 3- or 4-byte movement packets and publishes
// them on the 25-bit MOUSE bus, flipping MOUSE[24] on every completed packet.
module mouse_pkt_asm #(
  parameter int WHEEL   = 0,
  parameter int TIMEOUT = 2048
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  input  logic        RX_ERR,
  output logic [24:0] MOUSE,
  output logic        SYNC_ERR,
  output logic        BUSY
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // The abort fires on the tick that would take the count to TIMEOUT-1.
  localparam logic [CW-1:0] CNT_EXP = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_t;

  state_t        state_r, state_n, eff_state_s;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [7:0]    status_r, status_n;
  logic [7:0]    dx_r, dx_n;
  logic [7:0]    dy_r, dy_n;
  logic [7:0]    dy_src_s;
  logic [24:0]   mouse_r, mouse_n;
  logic          sync_err_r, sync_err_n;
  logic          busy_r;
  logic          commit_s;

  function automatic logic [7:0] sat_delta(input logic ovf, input logic sign,
                                           input logic [7:0] delta);
    if (ovf) begin
      sat_delta = sign ? 8'h01 : 8'hFF;
    end else begin
      sat_delta = delta;
    end
  endfunction

  // Next-state, byte capture, timeout and commit decode.
  always_comb begin
    state_n     = state_r;
    eff_state_s = state_r;
    cnt_n       = cnt_r;
    status_n    = status_r;
    dx_n        = dx_r;
    dy_n        = dy_r;
    dy_src_s    = dy_r;
    sync_err_n  = 1'b0;
    commit_s    = 1'b0;
    mouse_n     = mouse_r;

    if (RX_ERR) begin
      state_n    = IDLE;
      cnt_n      = {CW{1'b0}};
      sync_err_n = (state_r != IDLE);
    end else begin
      if (state_r == IDLE) begin
        cnt_n = {CW{1'b0}};
      end else if (CE && (cnt_r == CNT_EXP)) begin
        // A byte arriving on the expiry cycle is judged as a fresh byte 0.
        eff_state_s = IDLE;
        state_n     = IDLE;
        cnt_n       = {CW{1'b0}};
        sync_err_n  = 1'b1;
      end else if (CE) begin
        cnt_n = cnt_r + CW'(1);
      end else begin
        cnt_n = cnt_r;
      end

      if (RX_VALID) begin
        cnt_n = {CW{1'b0}};
        case (eff_state_s)
          IDLE: begin
            if (RX_DATA[3]) begin
              status_n = RX_DATA;
              state_n  = B1;
            end else begin
              sync_err_n = 1'b1;
              state_n    = IDLE;
            end
          end
          B1: begin
            dx_n    = RX_DATA;
            state_n = B2;
          end
          B2: begin
            dy_n = RX_DATA;
            if (WHEEL != 0) begin
              state_n = B3;
            end else begin
              dy_src_s = RX_DATA;
              commit_s = 1'b1;
              state_n  = IDLE;
            end
          end
          B3: begin
            commit_s = 1'b1;
            state_n  = IDLE;
          end
          default: begin
            state_n = IDLE;
          end
        endcase
      end else begin
        state_n = state_n;
      end
    end

    if (commit_s) begin
      mouse_n = {~mouse_r[24],
                 sat_delta(status_r[7], status_r[5], dy_src_s),
                 sat_delta(status_r[6], status_r[4], dx_r),
                 2'b00, status_r[5:0]};
    end else begin
      mouse_n = mouse_r;
    end
  end

  // State, payload and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      status_r   <= 8'h00;
      dx_r       <= 8'h00;
      dy_r       <= 8'h00;
      mouse_r    <= 25'd0;
      sync_err_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      status_r   <= status_n;
      dx_r       <= dx_n;
      dy_r       <= dy_n;
      mouse_r    <= mouse_n;
      sync_err_r <= sync_err_n;
      busy_r     <= (state_n != IDLE);
    end
  end

  assign MOUSE    = mouse_r;
  assign SYNC_ERR = sync_err_r;
  assign BUSY     = busy_r;

endmodule

// File: tb/tb_mouse_pkt_asm.sv
// Directed bench: a 3-byte instance and a wheel instance share one stimulus stream.
module tb_mouse_pkt_asm;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CE = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_ERR = 1'b0;
  logic [24:0] mouse0, mouse1;
  logic        sync_err0, sync_err1, busy0, busy1;

  int n_chk  = 0;
  int n_pass = 0;

  mouse_pkt_asm #(.WHEEL(0), .TIMEOUT(16)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_ERR(RX_ERR), .MOUSE(mouse0), .SYNC_ERR(sync_err0), .BUSY(busy0)
  );

  mouse_pkt_asm #(.WHEEL(1), .TIMEOUT(16)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_ERR(RX_ERR), .MOUSE(mouse1), .SYNC_ERR(sync_err1), .BUSY(busy1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one byte for one cycle; returns just after the sampling edge.
  task automatic send(input logic [7:0] b, input logic err);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    RX_ERR   = err;
    tick();
    RX_VALID = 1'b0;
    RX_ERR   = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    int first_k;
    int pulses;
    logic busy_at;
    logic [24:0] mouse_at;

    tick();
    tick();
    chk("reset_mouse", 32'(mouse0), 32'h0);
    chk("reset_busy", 32'(busy0), 32'h0);
    chk("reset_sync", 32'(sync_err0), 32'h0);
    RESET = 1'b0;

    // Normal 3-byte packets
    send(8'h09, 1'b0);
    chk("t1_busy_b1", 32'(busy0), 32'h1);
    send(8'h05, 1'b0);
    chk("t1_no_commit", 32'(mouse0), 32'h0);
    send(8'hFB, 1'b0);
    chk("t1_commit_a", 32'(mouse0), 32'h1FB0509);
    chk("t1_busy_done", 32'(busy0), 32'h0);
    send(8'h09, 1'b0);
    send(8'h05, 1'b0);
    send(8'hFB, 1'b0);
    chk("t1_commit_b", 32'(mouse0), 32'h0FB0509);

    // Resync on a byte without bit3
    send(8'h05, 1'b0);
    chk("t2_sync_pulse", 32'(sync_err0), 32'h1);
    chk("t2_busy", 32'(busy0), 32'h0);
    tick();
    chk("t2_sync_clear", 32'(sync_err0), 32'h0);
    send(8'h08, 1'b0);
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    chk("t2_commit", 32'(mouse0), 32'h1201008);
    chk("t2_no_sync", 32'(sync_err0), 32'h0);

    // Overflow saturation
    send(8'hD8, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    chk("t3_sat", 32'(mouse0), 32'h0FF0118);

    // Timeout after a lone status byte
    send(8'h08, 1'b0);
    first_k  = 0;
    pulses   = 0;
    busy_at  = 1'b1;
    mouse_at = 25'h1FFFFFF;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sync_err0) begin
        pulses++;
        if (first_k == 0) begin
          first_k  = k;
          busy_at  = busy0;
          mouse_at = mouse0;
        end
      end
    end
    chk("t4_pulse_delay", 32'(first_k), 32'd15);
    chk("t4_pulse_count", 32'(pulses), 32'd1);
    chk("t4_busy_fall", 32'(busy_at), 32'h0);
    chk("t4_mouse_kept", 32'(mouse_at), 32'h0FF0118);
    send(8'h08, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk("t4_next_commit", 32'(mouse0), 32'h1040308);

    // Byte arriving on the expiry cycle starts a new packet
    send(8'h08, 1'b0);
    repeat (14) tick();
    chk("t4b_still_busy", 32'(busy0), 32'h1);
    send(8'h28, 1'b0);
    chk("t4b_sync", 32'(sync_err0), 32'h1);
    chk("t4b_busy", 32'(busy0), 32'h1);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    chk("t4b_commit", 32'(mouse0), 32'h0020128);

    // Reset mid-packet
    send(8'h08, 1'b0);
    send(8'h03, 1'b0);
    do_reset();
    chk("t6_mouse_rst", 32'(mouse0), 32'h0);
    chk("t6_busy_rst", 32'(busy0), 32'h0);
    send(8'h08, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    chk("t6_commit", 32'(mouse0), 32'h1020108);

    // Wheel mode: 4-byte packet, then RX_ERR on byte 3
    do_reset();
    send(8'h08, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    chk("t5_wait_b3", 32'(mouse1), 32'h0);
    chk("t5_busy_b3", 32'(busy1), 32'h1);
    send(8'h7F, 1'b0);
    chk("t5_commit", 32'(mouse1), 32'h1020108);
    chk("t5_busy_done", 32'(busy1), 32'h0);
    send(8'h08, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    chk("t5_err_sync", 32'(sync_err1), 32'h1);
    chk("t5_err_idle", 32'(busy1), 32'h0);
    chk("t5_err_nocommit", 32'(mouse1), 32'h1020108);
    send(8'h08, 1'b1);
    chk("t5_err_idle_nosync", 32'(sync_err1), 32'h0);
    chk("t5_err_idle_busy", 32'(busy1), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
